lsu_pipe: RTL and testbench
===========================

LSU_PIPE -- requirements
Module: lsu_pipe

Interface
REQ-001 SHALL have parameter WIDTH_MEM, default 10: byte-address bits; data memory is 2^WIDTH_MEM bytes.
REQ-002 SHALL have parameter WIDTH_REG, default 5: destination register tag width.
REQ-003 SHALL have parameter WIDTH_BRM, default 4: branch mask width.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have ports i_valid 1, i_store 1 (0 load, 1 store) and i_funct3 3, all inputs: request qualifier, operation and RISC-V size/sign code.
REQ-007 SHALL have 32-bit inputs i_op1 (base), i_op2 (store data) and i_imm (offset), plus inputs i_rd [WIDTH_REG] and i_brmask [WIDTH_BRM].
REQ-008 SHALL have inputs i_kill 1, i_kill_mask [WIDTH_BRM] and i_resolve_mask [WIDTH_BRM]: mispredict squash and branch-resolution clear.
REQ-009 SHALL have outputs o_valid 1, o_data 32 and o_addr [WIDTH_REG]: load writeback.
REQ-010 SHALL have outputs o_fault 1 and o_fault_addr 32: access fault report.

Function
REQ-011 SHALL be a two-stage pipeline, S1 (address/memory) then OUT (writeback), accepting one request per cycle with no backpressure.
REQ-012 SHALL capture the request into S1 at each edge, with S1.valid = i_valid AND NOT kill-hit, where kill-hit = i_kill AND (mask & i_kill_mask) != 0.
REQ-013 SHALL store S1.brmask = i_brmask AND NOT i_resolve_mask on capture; an S1 entry that is not replaced keeps its mask with i_resolve_mask bits cleared each cycle.
REQ-014 SHALL clear S1.valid in the cycle i_kill hits its mask; a killed store SHALL NOT write memory and a killed load SHALL NOT raise o_valid or o_fault.
REQ-015 SHALL form addr = (i_op1 + i_imm) mod 2^32 and index memory with addr[WIDTH_MEM-1:0]; memory is byte-wide and little-endian.
REQ-016 SHALL decode loads as funct3 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU, and stores as 0 SB, 1 SH, 2 SW.
REQ-017 SHALL sign-extend LB/LH and zero-extend LBU/LHU.
REQ-018 SHALL flag a fault when any of the following holds: halfword with addr[0]=1; word with addr[1:0]!=0; addr[31:WIDTH_MEM]!=0; undefined funct3 (load 3/6/7, store >=3).
REQ-019 SHALL write a valid, non-faulting, non-killed S1 store to memory at the S1-exit edge, writing only the selected bytes (1/2/4 from i_op2 low bytes).
REQ-020 SHALL read memory combinationally in S1 for loads, so a load directly following a store to the same bytes returns the new data.
REQ-021 SHALL, for a valid non-faulting S1 load, register o_valid=1, o_data=extended value and o_addr=rd into OUT for exactly one cycle; o_data is valid 2 edges after request sampling.
REQ-022 SHALL, for a valid faulting S1 entry (load or store), register o_fault=1 and o_fault_addr=addr for one cycle, with o_valid=0 and no memory write.
REQ-023 SHALL give store completions no writeback: o_valid=0.
REQ-024 SHALL hold o_data/o_addr/o_fault_addr at their previous values when o_valid and o_fault are 0.
REQ-025 SHALL NOT apply i_kill to OUT contents.

Reset
REQ-026 SHALL, while i_rst=1, immediately force S1.valid=0, S1.brmask=0, o_valid=0, o_fault=0, o_data=0, o_addr=0 and o_fault_addr=0.
REQ-027 SHALL NOT initialise or alter memory contents on reset; an in-flight store asserted during reset SHALL NOT write.
REQ-028 SHALL sample the first request at the first rising edge after i_rst deasserts.

Verification
REQ-029 SHALL cover: SW op1=0x10 imm=0 op2=0xDEADBEEF, then LW/LH/LBU/LB at 0x10/0x12/0x13/0x13 back-to-back -> o_data 0xDEADBEEF, 0xFFFFDEAD, 0x000000DE, 0xFFFFFFDE on consecutive cycles.
REQ-030 SHALL cover: SB 0x7F at 0x21 followed next cycle by LW at 0x20 after SW 0 there -> 0x00007F00 (forward-in-order).
REQ-031 SHALL cover: LH at 0x11, LW at 0x22, LW at 2^WIDTH_MEM -> three o_fault pulses with o_fault_addr 0x11, 0x22, 0x400; o_valid stays 0; memory unchanged.
REQ-032 SHALL cover: SW brmask=0b0010 in S1 with i_kill=1 and i_kill_mask=0b0010 -> no write (later LW reads old value); the same with i_kill_mask=0b0100 -> write occurs.
REQ-033 SHALL cover: i_resolve_mask=0b0010 one cycle before i_kill with mask 0b0010 on that S1 entry -> entry survives.
REQ-034 SHALL cover: i_rst pulsed mid-cycle with a load in S1 -> o_valid=0 immediately, no writeback after release.

Source files
------------

// File: rtl/lsu_pipe.sv
// Two-stage load/store unit: S1 forms the address and accesses a byte-wide
// memory, OUT registers the load writeback or the access-fault report.
module lsu_pipe #(
  parameter int WIDTH_MEM = 10,
  parameter int WIDTH_REG = 5,
  parameter int WIDTH_BRM = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic                 i_store,
  input  logic [2:0]           i_funct3,
  input  logic [31:0]          i_op1,
  input  logic [31:0]          i_op2,
  input  logic [31:0]          i_imm,
  input  logic [WIDTH_REG-1:0] i_rd,
  input  logic [WIDTH_BRM-1:0] i_brmask,
  input  logic                 i_kill,
  input  logic [WIDTH_BRM-1:0] i_kill_mask,
  input  logic [WIDTH_BRM-1:0] i_resolve_mask,
  output logic                 o_valid,
  output logic [31:0]          o_data,
  output logic [WIDTH_REG-1:0] o_addr,
  output logic                 o_fault,
  output logic [31:0]          o_fault_addr
);
  localparam int DEPTH = 1 << WIDTH_MEM;

  logic [7:0] mem [DEPTH];

  logic                 s1_vld_q, s1_vld_d;
  logic [WIDTH_BRM-1:0] s1_brmask_q, s1_brmask_d;
  logic                 s1_store_q;
  logic [2:0]           s1_funct3_q;
  logic [31:0]          s1_op1_q, s1_op2_q, s1_imm_q;
  logic [WIDTH_REG-1:0] s1_rd_q;

  logic                 out_vld_q, out_vld_d;
  logic                 out_fault_q, out_fault_d;
  logic [31:0]          out_data_q, out_faddr_q;
  logic [WIDTH_REG-1:0] out_rd_q;

  logic                 s1_live, bad_f3, misalign, out_of_range, fault, we;
  logic [31:0]          addr, ld_val;
  logic [WIDTH_MEM-1:0] idx0, idx1, idx2, idx3;
  logic [7:0]           b0, b1, b2, b3;

  // ---- capture into S1 ----
  always_comb begin
    s1_vld_d    = i_valid & ~(i_kill & |(i_brmask & i_kill_mask));
    s1_brmask_d = i_brmask & ~i_resolve_mask;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_vld_q    <= 1'b0;
      s1_brmask_q <= '0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_brmask_q <= s1_brmask_d;
    end
  end

  always_ff @(posedge i_clk) begin
    s1_store_q  <= i_store;
    s1_funct3_q <= i_funct3;
    s1_op1_q    <= i_op1;
    s1_op2_q    <= i_op2;
    s1_imm_q    <= i_imm;
    s1_rd_q     <= i_rd;
  end

  // ---- S1: address, fault decode, memory access ----
  always_comb begin
    s1_live      = s1_vld_q & ~(i_kill & |(s1_brmask_q & i_kill_mask));
    addr         = s1_op1_q + s1_imm_q;
    idx0         = addr[WIDTH_MEM-1:0];
    idx1         = idx0 + WIDTH_MEM'(1);
    idx2         = idx0 + WIDTH_MEM'(2);
    idx3         = idx0 + WIDTH_MEM'(3);
    b0           = mem[idx0];
    b1           = mem[idx1];
    b2           = mem[idx2];
    b3           = mem[idx3];
    bad_f3       = s1_store_q ? (s1_funct3_q >= 3'd3)
                              : (s1_funct3_q == 3'd3 || s1_funct3_q[2:1] == 2'b11);
    misalign     = (s1_funct3_q[1:0] == 2'd1 && addr[0]) ||
                   (s1_funct3_q[1:0] == 2'd2 && addr[1:0] != 2'd0);
    out_of_range = (addr >> WIDTH_MEM) != 32'd0;
    fault        = bad_f3 | misalign | out_of_range;
    we           = s1_live & s1_store_q & ~fault;
    out_vld_d    = s1_live & ~s1_store_q & ~fault;
    out_fault_d  = s1_live & fault;
    case (s1_funct3_q)
      3'd0:    ld_val = {{24{b0[7]}}, b0};
      3'd1:    ld_val = {{16{b1[7]}}, b1, b0};
      3'd2:    ld_val = {b3, b2, b1, b0};
      3'd4:    ld_val = {24'd0, b0};
      3'd5:    ld_val = {16'd0, b1, b0};
      default: ld_val = 32'd0;
    endcase
  end

  // Memory has no reset; a store in S1 during reset is already squashed via s1_vld_q.
  always_ff @(posedge i_clk) begin
    if (we) begin
      mem[idx0] <= s1_op2_q[7:0];
      if (s1_funct3_q[1:0] != 2'd0) mem[idx1] <= s1_op2_q[15:8];
      if (s1_funct3_q[1:0] == 2'd2) begin
        mem[idx2] <= s1_op2_q[23:16];
        mem[idx3] <= s1_op2_q[31:24];
      end
    end
  end

  // ---- OUT: writeback / fault report ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_vld_q   <= 1'b0;
      out_fault_q <= 1'b0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
      out_faddr_q <= '0;
    end else begin
      out_vld_q   <= out_vld_d;
      out_fault_q <= out_fault_d;
      if (out_vld_d) begin
        out_data_q <= ld_val;
        out_rd_q   <= s1_rd_q;
      end
      if (out_fault_d) out_faddr_q <= addr;
    end
  end

  assign o_valid      = out_vld_q;
  assign o_fault      = out_fault_q;
  assign o_data       = out_data_q;
  assign o_addr       = out_rd_q;
  assign o_fault_addr = out_faddr_q;
endmodule

// File: tb/tb_lsu_pipe.sv
// Scoreboard bench for lsu_pipe: directed requests push expected writebacks or
// faults; a negedge monitor pops and compares whenever the DUT reports one.
module tb_lsu_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_valid = 0, i_store = 0, i_kill = 0;
  logic [2:0]  i_funct3 = 0;
  logic [31:0] i_op1 = 0, i_op2 = 0, i_imm = 0;
  logic [4:0]  i_rd = 0;
  logic [3:0]  i_brmask = 0, i_kill_mask = 0, i_resolve_mask = 0;
  logic        o_valid, o_fault;
  logic [31:0] o_data, o_fault_addr;
  logic [4:0]  o_addr;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_data = 0;

  typedef struct {
    bit          flt;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [31:0] faddr;
  } exp_t;
  exp_t sb[$];

  lsu_pipe #(.WIDTH_MEM(10), .WIDTH_REG(5), .WIDTH_BRM(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_store(i_store),
    .i_funct3(i_funct3), .i_op1(i_op1), .i_op2(i_op2), .i_imm(i_imm),
    .i_rd(i_rd), .i_brmask(i_brmask), .i_kill(i_kill),
    .i_kill_mask(i_kill_mask), .i_resolve_mask(i_resolve_mask),
    .o_valid(o_valid), .o_data(o_data), .o_addr(o_addr),
    .o_fault(o_fault), .o_fault_addr(o_fault_addr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && (o_valid || o_fault)) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got valid=%0b fault=%0b data=%h faddr=%h, required none",
                 o_valid, o_fault, o_data, o_fault_addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.flt) begin
          if (!(o_fault && !o_valid && o_fault_addr == e.faddr && o_data == last_data)) begin
            fails++;
            $display("FAIL fault_report: got fault=%0b valid=%0b faddr=%h data=%h, required fault=1 valid=0 faddr=%h data=%h",
                     o_fault, o_valid, o_fault_addr, o_data, e.faddr, last_data);
          end
        end else begin
          last_data = e.data;
          if (!(o_valid && !o_fault && o_data == e.data && o_addr == e.rd)) begin
            fails++;
            $display("FAIL load_wb: got valid=%0b fault=%0b data=%h rd=%0d, required valid=1 fault=0 data=%h rd=%0d",
                     o_valid, o_fault, o_data, o_addr, e.data, e.rd);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic st, input logic [2:0] f3, input logic [31:0] op1,
                     input logic [31:0] imm, input logic [31:0] op2, input logic [4:0] rd,
                     input logic [3:0] bm, input logic [3:0] res);
    i_valid = 1; i_store = st; i_funct3 = f3; i_op1 = op1; i_imm = imm;
    i_op2 = op2; i_rd = rd; i_brmask = bm; i_resolve_mask = res;
    step();
  endtask

  task automatic idle(input int n);
    i_valid = 0; i_kill = 0; i_kill_mask = 0; i_resolve_mask = 0; i_brmask = 0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic kill_cycle(input logic [3:0] km);
    i_valid = 0; i_kill = 1; i_kill_mask = km; i_resolve_mask = 0;
    step();
    i_kill = 0; i_kill_mask = 0;
  endtask

  task automatic exp_ld(input logic [31:0] d, input logic [4:0] rd);
    exp_t e;
    e.flt = 0; e.data = d; e.rd = rd; e.faddr = 0;
    sb.push_back(e);
  endtask

  task automatic exp_flt(input logic [31:0] a);
    exp_t e;
    e.flt = 1; e.data = 0; e.rd = 0; e.faddr = a;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  initial begin
    #1 rst = 1;
    #2;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_fault", {31'd0, o_fault}, 32'd0);
    chk("rst_data", o_data, 32'd0);
    chk("rst_faddr", o_fault_addr, 32'd0);
    step();
    rst = 0;
    idle(2);

    // byte/half/word loads after a word store
    req(1, 3'd2, 32'h10, 0, 32'hDEADBEEF, 0, 0, 0);
    req(0, 3'd2, 32'h10, 0, 0, 5'd1, 0, 0); exp_ld(32'hDEADBEEF, 5'd1);
    req(0, 3'd1, 32'h12, 0, 0, 5'd2, 0, 0); exp_ld(32'hFFFFDEAD, 5'd2);
    req(0, 3'd4, 32'h13, 0, 0, 5'd3, 0, 0); exp_ld(32'h000000DE, 5'd3);
    req(0, 3'd0, 32'h10, 32'h3, 0, 5'd4, 0, 0); exp_ld(32'hFFFFFFDE, 5'd4);
    req(0, 3'd5, 32'h10, 0, 0, 5'd5, 0, 0); exp_ld(32'h0000BEEF, 5'd5);

    // byte store merged into a zeroed word, read back next cycle
    req(1, 3'd2, 32'h20, 0, 32'h0, 0, 0, 0);
    req(1, 3'd0, 32'h20, 32'h1, 32'hAAAAAA7F, 0, 0, 0);
    req(0, 3'd2, 32'h20, 0, 0, 5'd6, 0, 0); exp_ld(32'h00007F00, 5'd6);
    idle(2);

    // faults: misaligned, out of range, bad funct3; none may write
    req(0, 3'd1, 32'h11, 0, 0, 5'd7, 0, 0); exp_flt(32'h11);
    req(0, 3'd2, 32'h20, 32'h2, 0, 5'd7, 0, 0); exp_flt(32'h22);
    req(0, 3'd2, 32'h400, 0, 0, 5'd7, 0, 0); exp_flt(32'h400);
    req(1, 3'd2, 32'h12, 0, 32'h12345678, 0, 0, 0); exp_flt(32'h12);
    req(1, 3'd2, 32'h420, 0, 32'h55555555, 0, 0, 0); exp_flt(32'h420);
    req(0, 3'd3, 32'h10, 0, 0, 5'd7, 0, 0); exp_flt(32'h10);
    req(1, 3'd3, 32'h20, 0, 32'hFFFFFFFF, 0, 0, 0); exp_flt(32'h20);
    req(0, 3'd2, 32'h10, 0, 0, 5'd8, 0, 0); exp_ld(32'hDEADBEEF, 5'd8);
    req(0, 3'd2, 32'h20, 0, 0, 5'd9, 0, 0); exp_ld(32'h00007F00, 5'd9);
    idle(2);

    // squash of a store in S1: hitting mask drops it, disjoint mask does not
    req(1, 3'd2, 32'h30, 0, 32'h11111111, 0, 0, 0);
    req(1, 3'd2, 32'h30, 0, 32'h22222222, 0, 4'b0010, 0);
    kill_cycle(4'b0010);
    req(0, 3'd2, 32'h30, 0, 0, 5'd10, 0, 0); exp_ld(32'h11111111, 5'd10);
    req(1, 3'd2, 32'h30, 0, 32'h22222222, 0, 4'b0010, 0);
    kill_cycle(4'b0100);
    req(0, 3'd2, 32'h30, 0, 0, 5'd11, 0, 0); exp_ld(32'h22222222, 5'd11);

    // resolved branch bit protects the entry from a later kill
    req(1, 3'd2, 32'h34, 0, 32'h33333333, 0, 4'b0010, 4'b0010);
    kill_cycle(4'b0010);
    req(0, 3'd2, 32'h34, 0, 0, 5'd12, 0, 0); exp_ld(32'h33333333, 5'd12);

    // request killed on the capture cycle never appears
    i_kill = 1; i_kill_mask = 4'b0001;
    req(0, 3'd2, 32'h10, 0, 0, 5'd13, 4'b0001, 0);
    i_kill = 0; i_kill_mask = 0;
    idle(3);

    // async reset pulse with a load sitting in S1
    req(0, 3'd2, 32'h10, 0, 0, 5'd14, 0, 0);
    i_valid = 0;
    #2 rst = 1;
    #1;
    chk("midrst_valid", {31'd0, o_valid}, 32'd0);
    chk("midrst_data", o_data, 32'd0);
    chk("midrst_rd", {27'd0, o_addr}, 32'd0);
    chk("midrst_faddr", o_fault_addr, 32'd0);
    rst = 0;
    last_data = 0;
    idle(3);
    req(0, 3'd2, 32'h10, 0, 0, 5'd15, 0, 0); exp_ld(32'hDEADBEEF, 5'd15);
    idle(1);

    for (int k = 0; k < 20 && sb.size() != 0; k++) step();
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL missing_output: got nothing, required flt=%0b data=%h faddr=%h",
               e.flt, e.data, e.faddr);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
